// File: rtl/alu_cmd_queue.sv
// Command queue and issue sequencer feeding the 8-bit ALU/accumulator stage.
// Buffers {func, a} pairs and replays them by button step or in run mode.
module alu_cmd_queue #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_btn,
    input  logic [2:0] cmd_func,
    input  logic [3:0] cmd_a,
    input  logic       issue_btn,
    input  logic       run,
    input  logic       flush,
    output logic [2:0] alu_func,
    output logic [3:0] alu_a,
    output logic       alu_load,
    output logic [4:0] count,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       done
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            push_hist_q, push_hist_d;
    logic            issue_hist_q, issue_hist_d;
    logic [6:0]      mem_q [DEPTH];
    logic [6:0]      mem_d [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [4:0]      count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [2:0]      alu_func_q, alu_func_d;
    logic [3:0]      alu_a_q, alu_a_d;
    logic            alu_load_q, alu_load_d;
    logic            done_q, done_d;

    logic            push_ev;
    logic            issue_ev;
    logic            is_empty;
    logic            is_full;
    logic            pop;
    logic            push_acc;
    logic            drop;

    // Sequencer: decides whether this cycle pops and where the FSM goes next
    always_comb begin
        push_ev  = push_btn & ~push_hist_q;
        issue_ev = issue_btn & ~issue_hist_q;
        is_empty = (count_q == 5'd0);
        is_full  = (count_q == DEPTH_C);
        pop      = 1'b0;
        state_d  = state_q;

        case (state_q)
            S_IDLE: begin
                if (run && !is_empty) begin
                    state_d = S_RUN;
                end else if (!run && issue_ev && !is_empty) begin
                    pop = 1'b1;
                end
            end
            S_RUN: begin
                if (!run || is_empty) begin
                    state_d = S_IDLE;
                end else begin
                    pop = 1'b1;
                    // A push alongside the final pop refills the queue, so stay in RUN
                    if (count_q == 5'd1 && !push_ev) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        push_acc = push_ev && (!is_full || pop);
        drop     = push_ev && is_full && !pop;

        if (flush) begin
            pop      = 1'b0;
            push_acc = 1'b0;
            drop     = 1'b0;
            state_d  = S_IDLE;
        end
    end

    // Storage, pointers, count and registered outputs
    always_comb begin
        push_hist_d  = push_btn;
        issue_hist_d = issue_btn;
        mem_d        = mem_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q | drop;
        alu_func_d   = alu_func_q;
        alu_a_d      = alu_a_q;
        alu_load_d   = pop;
        done_d       = (state_q == S_DONE) && !flush;

        if (push_acc) begin
            mem_d[wptr_q] = {cmd_func, cmd_a};
            wptr_d        = wptr_q + 1'b1;
        end

        if (pop) begin
            alu_func_d = mem_q[rptr_q][6:4];
            alu_a_d    = mem_q[rptr_q][3:0];
            rptr_d     = rptr_q + 1'b1;
        end

        case ({push_acc, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            push_hist_q  <= 1'b0;
            issue_hist_q <= 1'b0;
            for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            alu_func_q   <= '0;
            alu_a_q      <= '0;
            alu_load_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            push_hist_q  <= push_hist_d;
            issue_hist_q <= issue_hist_d;
            mem_q        <= mem_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            alu_func_q   <= alu_func_d;
            alu_a_q      <= alu_a_d;
            alu_load_q   <= alu_load_d;
            done_q       <= done_d;
        end
    end

    assign alu_func = alu_func_q;
    assign alu_a    = alu_a_q;
    assign alu_load = alu_load_q;
    assign count    = count_q;
    assign empty    = (count_q == 5'd0);
    assign full     = (count_q == DEPTH_C);
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed self-checking bench for alu_cmd_queue with DEPTH=8.
module tb_alu_cmd_queue;

    logic       clk;
    logic       reset_n;
    logic       push_btn;
    logic [2:0] cmd_func;
    logic [3:0] cmd_a;
    logic       issue_btn;
    logic       run;
    logic       flush;
    logic [2:0] alu_func;
    logic [3:0] alu_a;
    logic       alu_load;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;

    alu_cmd_queue #(.DEPTH(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_btn (push_btn),
        .cmd_func (cmd_func),
        .cmd_a    (cmd_a),
        .issue_btn(issue_btn),
        .run      (run),
        .flush    (flush),
        .alu_func (alu_func),
        .alu_a    (alu_a),
        .alu_load (alu_load),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [2:0] f, input logic [3:0] a);
        cmd_func = f;
        cmd_a    = a;
        push_btn = 1'b1;
        step();
        push_btn = 1'b0;
        step();
    endtask

    task automatic press_issue(input string tag, input logic [2:0] f, input logic [3:0] a,
                               input logic exp_load);
        issue_btn = 1'b1;
        step();
        chk({tag, "_load"}, 32'(alu_load), 32'(exp_load));
        chk({tag, "_func"}, 32'(alu_func), 32'(f));
        chk({tag, "_a"}, 32'(alu_a), 32'(a));
        issue_btn = 1'b0;
        step();
        chk({tag, "_load_off"}, 32'(alu_load), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        push_btn  = 1'b0;
        issue_btn = 1'b0;
        run       = 1'b0;
        flush     = 1'b0;
        cmd_func  = '0;
        cmd_a     = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        chk("rst_func", 32'(alu_func), 32'd0);
        chk("rst_a", 32'(alu_a), 32'd0);
        chk("rst_load", 32'(alu_load), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        step();

        // Reset in the middle of a run with three entries queued
        push_entry(3'd6, 4'h1);
        push_entry(3'd2, 4'h2);
        push_entry(3'd3, 4'h3);
        chk("mr_count3", 32'(count), 32'd3);
        run = 1'b1;
        step();
        chk("mr_enter_load", 32'(alu_load), 32'd0);
        step();
        chk("mr_pop_load", 32'(alu_load), 32'd1);
        chk("mr_pop_func", 32'(alu_func), 32'd6);
        chk("mr_pop_a", 32'(alu_a), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_async_load", 32'(alu_load), 32'd0);
        chk("mr_async_func", 32'(alu_func), 32'd0);
        chk("mr_async_a", 32'(alu_a), 32'd0);
        chk("mr_async_count", 32'(count), 32'd0);
        chk("mr_async_empty", 32'(empty), 32'd1);
        step();
        chk("mr_hold_load", 32'(alu_load), 32'd0);
        reset_n = 1'b1;
        step();
        chk("mr_after_load", 32'(alu_load), 32'd0);
        run = 1'b0;
        step();
        chk("mr_after_load2", 32'(alu_load), 32'd0);
        chk("mr_after_count", 32'(count), 32'd0);

        // Step-mode issue, third press on empty queue is ignored
        push_entry(3'b110, 4'h5);
        push_entry(3'b111, 4'h2);
        chk("st_count2", 32'(count), 32'd2);
        press_issue("st_i1", 3'b110, 4'h5, 1'b1);
        chk("st_count1", 32'(count), 32'd1);
        press_issue("st_i2", 3'b111, 4'h2, 1'b1);
        press_issue("st_i3", 3'b111, 4'h2, 1'b0);
        chk("st_empty", 32'(empty), 32'd1);

        // Fill to DEPTH, overflow on 9th push, flush
        for (int i = 0; i < 8; i++) push_entry(3'(i), 4'(i + 8));
        chk("of_count8", 32'(count), 32'd8);
        chk("of_full", 32'(full), 32'd1);
        chk("of_ovf0", 32'(overflow), 32'd0);
        push_entry(3'd0, 4'hF);
        chk("of_count_still8", 32'(count), 32'd8);
        chk("of_ovf1", 32'(overflow), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_ovf", 32'(overflow), 32'd0);
        chk("fl_empty", 32'(empty), 32'd1);
        chk("fl_full", 32'(full), 32'd0);
        chk("fl_load", 32'(alu_load), 32'd0);
        chk("fl_func_kept", 32'(alu_func), 32'd7);
        chk("fl_a_kept", 32'(alu_a), 32'h2);

        // Run mode drains four entries then pulses done
        for (int i = 1; i <= 4; i++) push_entry(3'(i), 4'(i));
        run = 1'b1;
        step();
        chk("rn_enter_load", 32'(alu_load), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("rn_load", 32'(alu_load), 32'd1);
            chk("rn_func", 32'(alu_func), 32'(i));
            chk("rn_a", 32'(alu_a), 32'(i));
            chk("rn_count", 32'(count), 32'(4 - i));
            chk("rn_done_low", 32'(done), 32'd0);
        end
        step();
        chk("rn_done", 32'(done), 32'd1);
        chk("rn_done_load", 32'(alu_load), 32'd0);
        step();
        chk("rn_done_off", 32'(done), 32'd0);
        cmd_func = 3'd5;
        cmd_a    = 4'h9;
        push_btn = 1'b1;
        step();
        chk("rp_count1", 32'(count), 32'd1);
        chk("rp_load0", 32'(alu_load), 32'd0);
        push_btn = 1'b0;
        step();
        chk("rp_enter_load", 32'(alu_load), 32'd0);
        step();
        chk("rp_load", 32'(alu_load), 32'd1);
        chk("rp_func", 32'(alu_func), 32'd5);
        chk("rp_a", 32'(alu_a), 32'h9);
        step();
        chk("rp_done", 32'(done), 32'd1);
        run = 1'b0;
        step();

        // Full queue, push coincident with a run-mode pop
        for (int i = 0; i < 8; i++) push_entry(3'(i), 4'(15 - i));
        run = 1'b1;
        step();
        cmd_func = 3'd5;
        cmd_a    = 4'hC;
        push_btn = 1'b1;
        step();
        chk("fp_load", 32'(alu_load), 32'd1);
        chk("fp_func", 32'(alu_func), 32'd0);
        chk("fp_a", 32'(alu_a), 32'hF);
        chk("fp_count", 32'(count), 32'd8);
        chk("fp_ovf", 32'(overflow), 32'd0);
        chk("fp_full", 32'(full), 32'd1);
        run      = 1'b0;
        push_btn = 1'b0;
        step();
        chk("fp_stop_load", 32'(alu_load), 32'd0);
        chk("fp_stop_count", 32'(count), 32'd8);
        run = 1'b1;
        step();
        for (int i = 1; i < 8; i++) begin
            step();
            chk("fd_func", 32'(alu_func), 32'(i));
            chk("fd_a", 32'(alu_a), 32'(15 - i));
        end
        step();
        chk("fd_last_func", 32'(alu_func), 32'd5);
        chk("fd_last_a", 32'(alu_a), 32'hC);
        chk("fd_last_count", 32'(count), 32'd0);
        step();
        chk("fd_done", 32'(done), 32'd1);
        run = 1'b0;
        step();

        // Held push button enqueues once
        cmd_func = 3'd1;
        cmd_a    = 4'h3;
        push_btn = 1'b1;
        repeat (20) step();
        chk("hold_count", 32'(count), 32'd1);
        push_btn = 1'b0;
        step();
        press_issue("hold_iss", 3'd1, 4'h3, 1'b1);
        chk("hold_empty", 32'(empty), 32'd1);

        // Pointer wrap, order preserved
        for (int i = 0; i < 20; i++) begin
            push_entry(3'(i), 4'(i * 3));
            press_issue("wrap", 3'(i), 4'(i * 3), 1'b1);
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_queue.md
# alu_cmd_queue

Command queue and issue sequencer that sits directly upstream of the 8-bit ALU/accumulator stage. The user enqueues {function, operand A} pairs from switches with a push button; the block replays them into the ALU one at a time, either stepped by a button or back-to-back in run mode. Each issued command drives the ALU function select and A operand and pulses a one-cycle load enable to the accumulator register.

## Interface
- DEPTH, 8, queue entries; power of two, 2..16
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- push_btn  in  1  active-high level; enqueue on 0->1 transition
- cmd_func  in  3  function code to enqueue (same encoding as ALU select)
- cmd_a  in  4  operand A to enqueue
- issue_btn  in  1  active-high level; step-issue on 0->1 transition
- run  in  1  level; 1 = issue continuously while queue non-empty
- flush  in  1  synchronous clear of queue contents and overflow
- alu_func  out  3  function select of last issued command
- alu_a  out  4  operand A of last issued command
- alu_load  out  1  one-cycle pulse, accumulator load enable
- count  out  5  entries held, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky; push attempted while full and not accepted
- done  out  1  one-cycle pulse when run mode drains queue to empty

## Operation
- Storage: DEPTH x 7-bit circular buffer {func, a}; write/read pointers of log2(DEPTH) bits wrap modulo DEPTH; count tracked separately.
- Edge detect: push_btn and issue_btn each registered once; event = current 1 and registered 0. Holding a button issues/enqueues exactly once.
- Push event: if not full, or full with a simultaneous pop, write at wptr, advance wptr. Full with no pop: drop entry, set overflow.
- Pop (issue): read at rptr, register into alu_func/alu_a, assert alu_load next cycle, advance rptr. Pop never occurs when empty; no bypass of an entry written the same cycle.
- Simultaneous push and pop: both performed, count unchanged.
- FSM states IDLE, RUN, DONE:
  - IDLE: pop on issue_btn event if not empty and run=0. Go RUN when run=1 and not empty.
  - RUN: pop every cycle. run=0 -> IDLE (no pop that cycle). Pop of last entry (count==1, no push) -> DONE. Push during last pop keeps RUN.
  - DONE: done=1 for one cycle, no pop, -> IDLE. issue_btn events ignored in RUN and DONE.
- Flush: highest priority; pointers, count, overflow cleared; in-flight push/pop that cycle discarded; FSM -> IDLE; alu_func/alu_a keep last value; alu_load forced 0 next cycle.
- Issue_btn event with empty queue: ignored, no alu_load.

## Timing
- Reset (async assert, sync release): alu_func=0, alu_a=0, alu_load=0, count=0, empty=1, full=0, overflow=0, done=0, FSM IDLE, pointers 0, button history 0.
- Push: button rises before edge k -> entry written at edge k; count/empty/full updated after edge k.
- Step issue: button rises before edge k -> alu_func/alu_a and alu_load=1 valid after edge k; alu_load back to 0 after edge k+1; func/a held until next issue.
- Run: entering RUN at edge k, pops at edges k+1, k+2, ... giving one alu_load per cycle; N entries -> N consecutive load pulses, done asserted the cycle after the last pulse.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset mid-run with 3 entries queued -> all outputs reset values immediately, count=0, no further alu_load.
- Push {3'b110,4'h5}, {3'b111,4'h2}, three issue_btn presses (run=0) -> two alu_load pulses with func/a 110/5 then 111/2; third press ignored; empty=1.
- Push 8 entries then a 9th with DEPTH=8 -> full=1, count=8, overflow=1, 9th value never issued; flush -> count=0, overflow=0.
- Queue 4 entries, run=1 held -> 4 consecutive alu_load cycles in FIFO order, done pulse one cycle later, FSM IDLE; push while run still 1 -> issued next cycles.
- Full queue, run=1, push event same cycle as pop -> accepted, overflow stays 0, count stays 8.
- Hold push_btn high 20 cycles -> exactly one entry enqueued; wrap test: 20 push/issue pairs -> pointers wrap, order preserved.
